pwm_regbank: RTL and testbench

// - Register bank and PWM generator sitting directly downstream of the SPI slave.
// - Consumes the slave's addr_reg / data_wr / wr_en and returns read data on data_rd_o.
// - Holds the control, prescale, period and per-channel duty registers.
// - Drives NUM_CH edge-aligned PWM outputs from one shared prescaled counter.

---
 rtl/pwm_regbank.sv | 138 +++++++++++++
 tb/tb_pwm_regbank.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/pwm_regbank.sv
// pwm_regbank: register bank plus NUM_CH edge-aligned PWM channels that share
// one prescaled period counter. Sits behind the SPI slave (addr/data/wr_en).
// Optional build macro PWM_SHADOW_EN: period/duty are double-buffered and only
// take effect at the period wrap, so outputs never glitch mid-period.
module pwm_regbank #(
   parameter int NUM_CH = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [7:0]        addr_i,
   input  logic [7:0]        data_wr_i,
   input  logic              wr_en_i,
   output logic [7:0]        data_rd_o,
   output logic [NUM_CH-1:0] pwm_o
);

   localparam logic [7:0] ADDR_CTRL   = 8'h00;
   localparam logic [7:0] ADDR_PRESC  = 8'h01;
   localparam logic [7:0] ADDR_PERIOD = 8'h02;
   localparam logic [7:0] ADDR_DUTY   = 8'h10;
   localparam logic [7:0] ADDR_ID     = 8'h7F;
   localparam logic [7:0] ID_VAL      = 8'hA5;
   // Only RUN and the implemented channel enables are storable in CTRL
   localparam logic [7:0] CTRL_MASK   = 8'h80 | 8'((1 << NUM_CH) - 1);

   logic                    r_wr_q;
   logic [7:0]              r_ctrl;
   logic [7:0]              r_presc;
   logic [7:0]              r_period;
   logic [NUM_CH-1:0][7:0]  r_duty;
   logic [7:0]              r_pcnt;
   logic [7:0]              r_cnt;
   logic [NUM_CH-1:0]       r_pwm;

   logic                    w_commit;
   logic                    w_run;
   logic                    w_tick;
   logic                    w_wrap;
   logic [7:0]              w_period_act;
   logic [NUM_CH-1:0][7:0]  w_duty_act;

   // wr_en_i is a level held for the whole SPI frame; commit only on its rising edge.
   // r_wr_q resets to 1 so a level already high at reset release is not taken as an edge.
   assign w_commit = wr_en_i & ~r_wr_q;
   assign w_run    = r_ctrl[7];
   assign w_tick   = w_run & (r_pcnt >= r_presc);
   // >= rather than == so a PERIOD lowered below cnt wraps at once instead of overrunning
   assign w_wrap   = w_tick & (r_cnt >= w_period_act);

   // Programmed registers and write-edge detector
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_q   <= 1'b1;
         r_ctrl   <= 8'h00;
         r_presc  <= 8'h00;
         r_period <= 8'hFF;
         r_duty   <= '0;
      end else begin
         r_wr_q <= wr_en_i;
         if (w_commit) begin
            case (addr_i)
               ADDR_CTRL:   r_ctrl   <= data_wr_i & CTRL_MASK;
               ADDR_PRESC:  r_presc  <= data_wr_i;
               ADDR_PERIOD: r_period <= data_wr_i;
               default: ;
            endcase
            for (int i = 0; i < NUM_CH; i++) begin
               if (addr_i == ADDR_DUTY + 8'(i)) r_duty[i] <= data_wr_i;
            end
         end
      end
   end

   // Readback decode from programmed (not active) values, valid same cycle
   always_comb begin
      data_rd_o = 8'h00;
      case (addr_i)
         ADDR_CTRL:   data_rd_o = r_ctrl;
         ADDR_PRESC:  data_rd_o = r_presc;
         ADDR_PERIOD: data_rd_o = r_period;
         ADDR_ID:     data_rd_o = ID_VAL;
         default: ;
      endcase
      for (int i = 0; i < NUM_CH; i++) begin
         if (addr_i == ADDR_DUTY + 8'(i)) data_rd_o = r_duty[i];
      end
   end

   // Prescaler and shared period counter; both parked at 0 while stopped
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pcnt <= 8'h00;
         r_cnt  <= 8'h00;
      end else if (!w_run) begin
         r_pcnt <= 8'h00;
         r_cnt  <= 8'h00;
      end else begin
         r_pcnt <= w_tick ? 8'h00 : r_pcnt + 8'd1;
         if (w_tick) r_cnt <= w_wrap ? 8'h00 : r_cnt + 8'd1;
      end
   end

`ifdef PWM_SHADOW_EN
   logic [7:0]              r_period_sh;
   logic [NUM_CH-1:0][7:0]  r_duty_sh;

   // Shadows track the programmed values while stopped, then only at the wrap tick
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_period_sh <= 8'hFF;
         r_duty_sh   <= '0;
      end else if (!w_run || w_wrap) begin
         r_period_sh <= r_period;
         r_duty_sh   <= r_duty;
      end
   end

   assign w_period_act = r_period_sh;
   assign w_duty_act   = r_duty_sh;
`else
   assign w_period_act = r_period;
   assign w_duty_act   = r_duty;
`endif

   // Registered compare per channel; async reset forces outputs low immediately
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pwm <= '0;
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            r_pwm[i] <= w_run & r_ctrl[i] & (r_cnt < w_duty_act[i]);
         end
      end
   end

   assign pwm_o = r_pwm;

endmodule

// File: tb/tb_pwm_regbank.sv
module tb_pwm_regbank;

  localparam int NUM_CH = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [7:0]        addr_i = 8'h00;
  logic [7:0]        data_wr_i = 8'h00;
  logic              wr_en_i = 1'b0;
  logic [7:0]        data_rd_o;
  logic [NUM_CH-1:0] pwm_o;

  always #5 clk = ~clk;

  pwm_regbank #(.NUM_CH(NUM_CH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .addr_i    (addr_i),
    .data_wr_i (data_wr_i),
    .wr_en_i   (wr_en_i),
    .data_rd_o (data_rd_o),
    .pwm_o     (pwm_o)
  );

  typedef struct {
    int         kind;
    logic [7:0] mask;
    logic [7:0] exp;
    logic [7:0] got;
    string      name;
  } chk_t;

  chk_t sb_q[$];
  event ev_chk;
  int   n_chk = 0;
  int   n_err = 0;

  initial begin
    forever begin
      @(ev_chk);
      while (sb_q.size() > 0) begin
        chk_t       c;
        logic [7:0] act;
        c = sb_q.pop_front();
        if (c.kind == 0)      act = data_rd_o;
        else if (c.kind == 1) act = 8'(pwm_o);
        else                  act = c.got;
        n_chk++;
        if ((act & c.mask) !== (c.exp & c.mask)) begin
          n_err++;
          $display("FAIL %s: got 0x%02h expected 0x%02h (mask 0x%02h)",
                   c.name, act, c.exp, c.mask);
        end
      end
    end
  end

  task automatic chk_now(input logic [7:0] got, input logic [7:0] e, input string name);
    n_chk++;
    if (got !== e) begin
      n_err++;
      $display("FAIL %s: got 0x%02h expected 0x%02h", name, got, e);
    end
  endtask

  task automatic push(input int kind, input logic [7:0] mask, input logic [7:0] exp,
                      input logic [7:0] got, input string name);
    chk_t c;
    c.kind = kind; c.mask = mask; c.exp = exp; c.got = got; c.name = name;
    sb_q.push_back(c);
    -> ev_chk;
    #0;
  endtask

  task automatic exp_rd(input logic [7:0] a, input logic [7:0] e, input string name);
    addr_i = a;
    #1;
    push(0, 8'hFF, e, 8'h00, name);
  endtask

  task automatic exp_pwm(input logic [7:0] mask, input logic [7:0] e, input string name);
    push(1, mask, e, 8'h00, name);
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    addr_i = a; data_wr_i = d; wr_en_i = 1'b1;
    @(negedge clk);
    wr_en_i = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_rise(output bit ok);
    logic prev;
    ok = 1'b0;
    prev = pwm_o[0];
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (pwm_o[0] && !prev) begin
        ok = 1'b1;
        break;
      end
      prev = pwm_o[0];
    end
  endtask

  initial begin
    bit         ok;
    logic [7:0] e;

    repeat (3) @(negedge clk);
    chk_now(8'(pwm_o), 8'h00, "rst_pwm");
    exp_rd(8'h00, 8'h00, "rst_ctrl");
    exp_rd(8'h01, 8'h00, "rst_presc");
    exp_rd(8'h02, 8'hFF, "rst_period");
    exp_rd(8'h10, 8'h00, "rst_duty0");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    wr(8'h01, 8'h03);
    exp_rd(8'h01, 8'h03, "presc_rb");
    exp_rd(8'h7F, 8'hA5, "id");
    exp_rd(8'h40, 8'h00, "unmapped");
    wr(8'h7F, 8'h00);
    exp_rd(8'h7F, 8'hA5, "id_ro");
    wr(8'h40, 8'h5A);
    exp_rd(8'h40, 8'h00, "unmapped_wr");

    @(negedge clk);
    addr_i = 8'h10; data_wr_i = 8'h11; wr_en_i = 1'b1;
    for (int i = 1; i < 50; i++) begin
      @(negedge clk);
      data_wr_i = 8'(8'h20 + i);
    end
    @(negedge clk);
    wr_en_i = 1'b0;
    @(negedge clk);
    exp_rd(8'h10, 8'h11, "held_wr");

    wr(8'h01, 8'h01);
    wr(8'h02, 8'h09);
    wr(8'h10, 8'h03);
    wr(8'h00, 8'h81);
    exp_rd(8'h00, 8'h81, "ctrl_rb");
    wait_rise(ok);
    chk_now(8'(ok), 8'h01, "wave_timeout");
    if (ok) begin
      for (int k = 0; k < 40; k++) begin
        if (k > 0) @(negedge clk);
        exp_pwm(8'h0F, ((k % 20) < 6) ? 8'h01 : 8'h00, $sformatf("wave_k%0d", k));
      end
    end

    wait_rise(ok);
    chk_now(8'(ok), 8'h01, "shadow_timeout");
    if (ok) begin
      exp_pwm(8'h01, 8'h01, "shadow_k0");
      addr_i = 8'h10; data_wr_i = 8'h07; wr_en_i = 1'b1;
      for (int k = 1; k < 40; k++) begin
        @(negedge clk);
        if (k == 1) wr_en_i = 1'b0;
`ifdef PWM_SHADOW_EN
        if (k < 20) e = (k < 6) ? 8'h01 : 8'h00;
        else        e = ((k % 20) < 14) ? 8'h01 : 8'h00;
`else
        e = ((k % 20) < 14) ? 8'h01 : 8'h00;
`endif
        exp_pwm(8'h01, e, $sformatf("shadow_k%0d", k));
      end
    end

    wr(8'h11, 8'h00);
    wr(8'h12, 8'hFF);
    wr(8'h00, 8'h87);
    repeat (25) @(negedge clk);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      exp_pwm(8'h06, 8'h04, $sformatf("lim_duty_k%0d", k));
    end

    wr(8'h02, 8'h00);
    wr(8'h13, 8'h01);
    wr(8'h00, 8'h8F);
    repeat (25) @(negedge clk);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      exp_pwm(8'h0F, 8'h0D, $sformatf("lim_p0_k%0d", k));
    end

    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    exp_pwm(8'hFF, 8'h00, "async_rst");
    addr_i = 8'h01; data_wr_i = 8'h55; wr_en_i = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    wr_en_i = 1'b0;
    @(negedge clk);
    exp_rd(8'h01, 8'h00, "wr_at_release");
    exp_rd(8'h00, 8'h00, "ctrl_after_rst");
    exp_rd(8'h02, 8'hFF, "period_after_rst");
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      exp_pwm(8'hFF, 8'h00, $sformatf("idle_k%0d", k));
    end

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
